instr_loader: RTL and testbench
===============================

# instr_loader

Boot-time program loader that writes instruction memory. It is the writer counterpart to the CPU fetch port, which only reads. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, writes them to consecutive word addresses of the instruction memory write port, and holds the CPU in reset until a frame loads cleanly. It sits between the host byte source and the `instr_mem` write port; `cpu_hold` ORs into the core's `rst`.

## Interface
- `ADDRESS_WIDTH`, default 8: instruction-memory byte-address width; capacity is 2^ADDRESS_WIDTH/4 words.
- `DATA_WIDTH`, default 32: instruction word width; fixed at 32.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs on an edge with `in_valid && in_ready`.
- `wr_en`  out  1  instruction-memory write strobe, one cycle per word.
- `wr_addr`  out  ADDRESS_WIDTH  word-aligned byte address.
- `wr_data`  out  DATA_WIDTH  word to write.
- `cpu_hold`  out  1  keep the CPU in reset.
- `load_done`  out  1  one-cycle pulse when a frame is accepted.
- `load_err`  out  1  sticky error flag; cleared when the next header is accepted.

## Operation
- Frame format:
  - header `0xA5`
  - N_lo, N_hi: 16-bit word count
  - N×4 payload bytes, each word least-significant byte first
  - checksum byte: 8-bit sum mod 256 of the payload bytes only
- States and transitions:
  - IDLE: discard every byte except `0xA5`. On `0xA5`, go to LEN0, clear `load_err`, clear `booted`.
  - LEN0: capture N_lo, go to LEN1.
  - LEN1: capture N_hi.
    - If N > 2^ADDRESS_WIDTH/4: set `load_err`, return to IDLE, no writes.
    - If N = 0: go to CSUM.
    - Otherwise go to DATA with word index k=0, byte lane 0, sum=0.
  - DATA: shift the byte into lane 0..3 and add it to sum.
    - On lane 3, the assembled word {b3,b2,b1,b0} is written at `wr_addr` = 4·k.
    - After word N−1, go to CSUM.
  - CSUM: compare the byte with sum.
    - Match: set `booted`, pulse `load_done`.
    - Mismatch: set `load_err`.
    - Either way, return to IDLE.
- `cpu_hold` = !booted || state≠IDLE. A failed or oversize reload after a prior success keeps `cpu_hold` high until a later frame succeeds.
- Address arithmetic: `wr_addr` is k shifted left 2, truncated to ADDRESS_WIDTH. N = capacity ends at 2^ADDRESS_WIDTH−4 and never wraps.
- `in_ready` is 1 in every state once out of reset. The write port has no backpressure.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=1, `load_done`=0, `load_err`=0, state=IDLE, `booted`=0.
- Reset is asserted asynchronously. `in_ready` rises on the first `clk` edge after `rst` deasserts.
- Input bubbles (`in_valid`=0) freeze all state.
- `wr_en`, `wr_addr`, `wr_data` are registered: valid the cycle after the lane-3 byte is accepted, high for exactly one cycle.
- Checksum byte accepted on edge t:
  - on match, `load_done`=1 for cycle t+1 and `cpu_hold` falls at t+1;
  - on mismatch, `load_err` rises at t+1.
- Oversize count: `load_err` rises the cycle after the N_hi byte is accepted.
- `load_err` clears the cycle after a `0xA5` is accepted in IDLE.
- Reset mid-frame: immediate return to reset values. Memory contents already written are unspecified; the next frame must still load correctly.

## Test plan
- Reset: hold `rst`=0 → `cpu_hold`=1 and all other outputs 0. Release → `in_ready`=1 one edge later.
- Two-word load: stream A5 02 00 13 05 10 00 93 05 20 00 E0.
  - Writes (0x00, 0x00100513), then (0x04, 0x00200593).
  - `load_done` pulses once, `cpu_hold`→0, `load_err`=0.
- Bad checksum: same stream ending E1.
  - Both writes occur.
  - `load_err`=1, `load_done` never pulses, `cpu_hold` stays 1.
- Bounds, ADDRESS_WIDTH=8:
  - A5 41 00 → `load_err`=1, no `wr_en`.
  - A 64-word frame with payload bytes i mod 256 → last write at 0xFC, then `load_done`.
- Noise and bubbles: bytes 00 FF, then A5 00 00 00 with random `in_valid` gaps → no writes, `load_done` pulses, `cpu_hold`→0.
- Reset mid-payload: drop `rst` after 5 payload bytes, release, then send the full two-word frame → same response as the two-word load scenario.

Source files
------------

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - framed byte-stream loader that writes instruction memory
// and holds the CPU in reset until a frame with a good checksum has loaded.
module instr_loader #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     cpu_hold,
  output logic                     load_done,
  output logic                     load_err
);

  localparam logic [16:0] CAPACITY = 17'(1) << (ADDRESS_WIDTH - 2);
  localparam logic [7:0]  HEADER   = 8'hA5;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM} state_t;

  state_t      state;
  logic        booted;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [15:0] k;
  logic [1:0]  lane;
  logic [7:0]  sum;
  logic [23:0] shift;
  logic [15:0] n_req;
  logic        accept;

  assign n_req  = {in_data, n_lo};
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      booted    <= 1'b0;
      n_lo      <= '0;
      n_words   <= '0;
      k         <= '0;
      lane      <= '0;
      sum       <= '0;
      shift     <= '0;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      in_ready  <= 1'b1;
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (in_data == HEADER) begin
              state    <= LEN0;
              load_err <= 1'b0;
              booted   <= 1'b0;
              cpu_hold <= 1'b1;
            end
          end
          LEN0: begin
            n_lo  <= in_data;
            state <= LEN1;
          end
          LEN1: begin
            n_words <= n_req;
            k       <= '0;
            lane    <= '0;
            sum     <= '0;
            if ({1'b0, n_req} > CAPACITY) begin
              load_err <= 1'b1;
              state    <= IDLE;
            end else if (n_req == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            // Bytes arrive LSB first, so each new byte enters at the top.
            shift <= {in_data, shift[23:8]};
            sum   <= sum + in_data;
            lane  <= lane + 2'd1;
            if (lane == 2'd3) begin
              wr_en   <= 1'b1;
              wr_addr <= {k[ADDRESS_WIDTH-3:0], 2'b00};
              wr_data <= {in_data, shift};
              k       <= k + 16'd1;
              if (k == n_words - 16'd1) state <= CSUM;
            end
          end
          CSUM: begin
            if (in_data == sum) begin
              booted    <= 1'b1;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              load_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized frame stimulus checked every cycle against
// a position-in-frame reference model, plus literal checks of directed scenarios.
module tb_instr_loader;
  localparam int AW  = 8;
  localparam int CAP = (1 << AW) / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  instr_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit gaps   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks how many bytes of the current frame have been seen.
  bit          m_active, m_booted, m_err;
  int          m_pos, m_n;
  logic [7:0]  m_nlo, m_sum;
  logic [7:0]  m_b [4];
  bit          e_ready, e_wr_en, e_done;
  logic [7:0]  e_addr;
  logic [31:0] e_data;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_active = 0; m_booted = 0; m_err = 0;
      e_ready = 0; e_wr_en = 0; e_done = 0; e_addr = 0; e_data = 0;
    end else begin
      e_wr_en = 0;
      e_done  = 0;
      if (in_valid && e_ready) begin
        if (!m_active) begin
          if (in_data == 8'hA5) begin
            m_active = 1; m_pos = 0; m_err = 0; m_booted = 0;
          end
        end else begin
          if (m_pos == 0) m_nlo = in_data;
          else if (m_pos == 1) begin
            m_n   = {in_data, m_nlo};
            m_sum = 0;
            if (m_n > CAP) begin m_err = 1; m_active = 0; end
          end else if (m_pos < 2 + 4 * m_n) begin
            m_sum = m_sum + in_data;
            m_b[(m_pos - 2) % 4] = in_data;
            if ((m_pos - 2) % 4 == 3) begin
              e_wr_en = 1;
              e_addr  = 8'(((m_pos - 2) / 4) * 4);
              e_data  = {m_b[3], m_b[2], m_b[1], m_b[0]};
            end
          end else begin
            if (in_data == m_sum) begin m_booted = 1; e_done = 1; end
            else m_err = 1;
            m_active = 0;
          end
          m_pos++;
        end
      end
      e_ready = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(e_ready));
    chk("wr_en", 32'(wr_en), 32'(e_wr_en));
    chk("wr_addr", 32'(wr_addr), 32'(e_addr));
    chk("wr_data", wr_data, e_data);
    chk("load_done", 32'(load_done), 32'(e_done));
    chk("load_err", 32'(load_err), 32'(m_err));
    chk("cpu_hold", 32'(cpu_hold), 32'(!m_booted || m_active));
  end

  // Observation log for the directed scenarios.
  logic [39:0] wr_q[$];
  int          done_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (wr_en) wr_q.push_back({wr_addr, wr_data});
    if (load_done) done_cnt++;
  end

  task automatic clear_log();
    wr_q.delete();
    done_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 0; in_data = 8'($urandom); @(negedge clk);
      end
    end
    in_valid = 1; in_data = b; @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    in_valid = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_two_word(input logic [7:0] csum);
    logic [7:0] s [12];
    s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hE0};
    s[11] = csum;
    foreach (s[i]) send_byte(s[i]);
    drain();
  endtask

  task automatic check_two_word_ok(input string tag);
    chk({tag, "_nwr"}, 32'(wr_q.size()), 32'd2);
    if (wr_q.size() == 2) begin
      chk({tag, "_w0"}, 32'(wr_q[0][39:32]), 32'h00);
      chk({tag, "_d0"}, wr_q[0][31:0], 32'h00100513);
      chk({tag, "_w1"}, 32'(wr_q[1][39:32]), 32'h04);
      chk({tag, "_d1"}, wr_q[1][31:0], 32'h00200593);
    end
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst = 0;
    @(negedge clk);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk); #2 rst = 1;
    @(negedge clk);
    chk("rel_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_hold", 32'(cpu_hold), 32'd1);
    chk("reset_err", 32'(load_err), 32'd0);
    #2 rst = 1;
    @(negedge clk);
    chk("release_ready", 32'(in_ready), 32'd1);

    clear_log();
    send_two_word(8'hE0);
    check_two_word_ok("two");

    clear_log();
    send_two_word(8'hE1);
    chk("bad_nwr", 32'(wr_q.size()), 32'd2);
    chk("bad_err", 32'(load_err), 32'd1);
    chk("bad_done", 32'(done_cnt), 32'd0);
    chk("bad_hold", 32'(cpu_hold), 32'd1);

    clear_log();
    send_byte(8'hA5); send_byte(8'h41); send_byte(8'h00); drain();
    chk("over_err", 32'(load_err), 32'd1);
    chk("over_nwr", 32'(wr_q.size()), 32'd0);

    clear_log();
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    send_byte(8'h80);
    drain();
    chk("full_nwr", 32'(wr_q.size()), 32'd64);
    if (wr_q.size() == 64) begin
      chk("full_last_addr", 32'(wr_q[63][39:32]), 32'hFC);
      chk("full_last_data", wr_q[63][31:0], 32'hFFFEFDFC);
    end
    chk("full_done", 32'(done_cnt), 32'd1);

    clear_log();
    gaps = 1;
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    drain();
    chk("noise_nwr", 32'(wr_q.size()), 32'd0);
    chk("noise_done", 32'(done_cnt), 32'd1);
    chk("noise_hold", 32'(cpu_hold), 32'd0);
    gaps = 0;

    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00); send_byte(8'h93);
    do_reset();
    clear_log();
    send_two_word(8'hE0);
    check_two_word_ok("midrst");

    gaps = 1;
    for (int f = 0; f < 25; f++) begin
      int n;
      logic [7:0] s;
      s = 0;
      repeat ($urandom_range(0, 3)) send_byte(8'($urandom));
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(65, 300) : $urandom_range(0, 20);
      send_byte(8'hA5); send_byte(8'(n)); send_byte(8'(n >> 8));
      if (n <= CAP) begin
        for (int i = 0; i < 4 * n; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          s = s + b;
          send_byte(b);
        end
        send_byte(($urandom_range(0, 3) == 0) ? s ^ 8'(1 << $urandom_range(0, 7)) : s);
      end
      if (f == 12) do_reset();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
